// File: rtl/sfp_link_pkg.sv
// ---------------------------------------------------------------------------
// sfp_link_pkg
// Constants and types shared by the SFP serial link transmit and receive
// sides.
//   FRAME_DATA_BITS : data bits per frame (LSB first)
//   LINE_IDLE       : level of an idle line
//   START_BIT       : level of the start bit
//   STOP_BIT        : level of the stop bit
//   rx_state_t      : receive FSM states
// ---------------------------------------------------------------------------
package sfp_link_pkg;

   localparam int   FRAME_DATA_BITS = 8;
   localparam logic LINE_IDLE       = 1'b1;
   localparam logic START_BIT       = 1'b0;
   localparam logic STOP_BIT        = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Multi-flop synchronizer for a single asynchronous input. Every stage
// resets to 1 so that an idle-high line does not look like a falling edge
// when reset is released.
//   clk     : destination clock
//   rst     : asynchronous active-high reset
//   i_async : asynchronous input
//   o_sync  : synchronized copy, STAGES cycles late
// ---------------------------------------------------------------------------
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/sfp_serial_rx.sv
// ---------------------------------------------------------------------------
// sfp_serial_rx
// Receives 8-bit switch frames (start 0, 8 data bits LSB first, stop 1)
// from the SFP receive line by oversampling in the fabric clock domain.
// Good bytes are presented on data_out and mirrored on led_out; a stop bit
// sampled low raises a single frame_err pulse.
//   clk        : fabric clock
//   rst        : asynchronous active-high reset
//   sfp_rx     : asynchronous serial line, idle high
//   data_out   : last good byte
//   data_valid : one-cycle pulse when data_out updates
//   frame_err  : one-cycle pulse when the stop bit samples 0
//   busy       : high whenever the receiver is not idle
//   led_out    : registered copy of data_out for the LEDs
// CLKS_PER_BIT must be >= 4 and SYNC_STAGES >= 2.
// ---------------------------------------------------------------------------
module sfp_serial_rx
   import sfp_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sfp_rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy,
   output logic [7:0] led_out
);

   localparam int TICK_W = $clog2(CLKS_PER_BIT);
   localparam int HALF   = CLKS_PER_BIT / 2;
   localparam int IDX_W  = $clog2(FRAME_DATA_BITS);

   localparam logic [TICK_W-1:0] HALF_LAST    = TICK_W'(HALF - 1);
   localparam logic [TICK_W-1:0] BIT_LAST     = TICK_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  LAST_BIT_IDX = IDX_W'(FRAME_DATA_BITS - 1);

   logic w_rx_s;

   rx_state_t                  r_state;
   logic [TICK_W-1:0]          r_tick;
   logic [IDX_W-1:0]           r_bit_idx;
   logic [FRAME_DATA_BITS-1:0] r_shift;
   logic [7:0]                 r_data;
   logic [7:0]                 r_led;
   logic                       r_valid;
   logic                       r_ferr;
   logic                       r_busy;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (sfp_rx),
      .o_sync  (w_rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_tick    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_led     <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         // Pulses last exactly one cycle unless re-asserted below.
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;

         unique case (r_state)
            IDLE: begin
               if (w_rx_s == START_BIT) begin
                  r_state <= START;
                  r_tick  <= '0;
                  r_busy  <= 1'b1;
               end
            end

            START: begin
               // Re-check at mid start bit so short glitches are rejected.
               if (r_tick == HALF_LAST) begin
                  if (w_rx_s == START_BIT) begin
                     r_state   <= DATA;
                     r_tick    <= '0;
                     r_bit_idx <= '0;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_tick <= r_tick + TICK_W'(1);
               end
            end

            DATA: begin
               // Counting a full bit from mid start bit lands on mid data bit.
               if (r_tick == BIT_LAST) begin
                  r_tick             <= '0;
                  r_shift[r_bit_idx] <= w_rx_s;
                  if (r_bit_idx == LAST_BIT_IDX) begin
                     r_state <= STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                  end
               end else begin
                  r_tick <= r_tick + TICK_W'(1);
               end
            end

            STOP: begin
               if (r_tick == BIT_LAST) begin
                  r_tick <= '0;
                  if (w_rx_s == STOP_BIT) begin
                     // Back to IDLE at mid stop bit, leaving half a bit of
                     // margin for a start bit that follows immediately.
                     r_data  <= r_shift;
                     r_led   <= r_shift;
                     r_valid <= 1'b1;
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= BREAK;
                  end
               end else begin
                  r_tick <= r_tick + TICK_W'(1);
               end
            end

            BREAK: begin
               // A held-low line must not be mistaken for new start bits.
               if (w_rx_s == LINE_IDLE) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out   = r_data;
   assign led_out    = r_led;
   assign data_valid = r_valid;
   assign frame_err  = r_ferr;
   assign busy       = r_busy;

endmodule

// File: tb/tb_sfp_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_sfp_serial_rx
// Self-checking bench for sfp_serial_rx with CLKS_PER_BIT = 8. Frames are
// built bit by bit from the byte value; the reference model keeps a queue of
// bytes that must appear on data_valid, expected pulse counts and the last
// good byte.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sfp_serial_rx;

   localparam int CPB  = 8;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sfp_rx = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;
   logic [7:0] led_out;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0] exp_q[$];
   logic [7:0] model_last = 8'h00;
   int         dv_exp = 0;
   int         fe_exp = 0;
   int         dv_seen = 0;
   int         fe_seen = 0;

   always #5 clk = ~clk;

   sfp_serial_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sfp_rx     (sfp_rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy),
      .led_out    (led_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Output monitor: every data_valid must match the next expected byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid || frame_err) begin
            check("dv_fe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
         end
         if (data_valid) begin
            dv_seen++;
            if (exp_q.size() == 0) begin
               check("dv_unexpected", 32'd1, 32'd0);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               check("dv_data_out", {24'd0, data_out}, {24'd0, e});
               check("dv_led_out", {24'd0, led_out}, {24'd0, e});
               $display("rx byte 0x%02h (expected 0x%02h)", data_out, e);
            end
         end
         if (frame_err) begin
            fe_seen++;
            $display("rx frame_err, data_out 0x%02h", data_out);
         end
      end
   end

   task automatic bit_out(input logic v);
      sfp_rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle(input int n);
      sfp_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Send one frame; a bad stop holds the line low for low_hold cycles.
   task automatic send_frame(input logic [7:0] b, input bit good_stop, input int low_hold);
      $display("tx frame 0x%02h good_stop=%0d", b, good_stop);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      if (good_stop) begin
         exp_q.push_back(b);
         model_last = b;
         dv_exp++;
         bit_out(1'b1);
      end else begin
         fe_exp++;
         sfp_rx = 1'b0;
         repeat (low_hold) @(negedge clk);
         sfp_rx = 1'b1;
      end
   endtask

   task automatic check_settled(input string tag);
      check({tag, "_dv_count"}, dv_seen, dv_exp);
      check({tag, "_fe_count"}, fe_seen, fe_exp);
      check({tag, "_data"}, {24'd0, data_out}, {24'd0, model_last});
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int busy_cycles;
      repeat (3) @(negedge clk);
      // Reset state
      check("rst_data", {24'd0, data_out}, 32'd0);
      check("rst_led", {24'd0, led_out}, 32'd0);
      check("rst_dv", {31'd0, data_valid}, 32'd0);
      check("rst_fe", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      idle(2 * CPB);

      // 1: single frame
      send_frame(8'hA5, 1'b1, 0);
      idle(2 * CPB);
      check_settled("t1");
      check("t1_led", {24'd0, led_out}, 32'h0000_00A5);

      // 2: back-to-back frames, single stop bit between them
      send_frame(8'h3C, 1'b1, 0);
      send_frame(8'hC3, 1'b1, 0);
      idle(2 * CPB);
      check_settled("t2");

      // 3: short low glitch on an idle line
      busy_cycles = 0;
      sfp_rx = 1'b0;
      @(negedge clk); busy_cycles += int'(busy);
      @(negedge clk); busy_cycles += int'(busy);
      sfp_rx = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         busy_cycles += int'(busy);
      end
      $display("glitch: busy for %0d cycles", busy_cycles);
      check("t3_busy_seen", {31'd0, busy_cycles > 0}, 32'd1);
      check("t3_busy_short", {31'd0, busy_cycles < CPB}, 32'd1);
      check_settled("t3");

      // 4: bad stop bit, line held low for 40 cycles
      send_frame(8'h55, 1'b0, 40);
      sfp_rx = 1'b0;
      check("t4_busy_held", {31'd0, busy}, 32'd1);
      check("t4_fe_count", fe_seen, fe_exp);
      check("t4_data_kept", {24'd0, data_out}, {24'd0, model_last});
      idle(2 * CPB);
      check_settled("t4");

      // 5: reset during data bit 4 of 0xFF
      $display("tx frame 0xFF aborted by reset");
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(1'b1);
      repeat (CPB / 2) @(negedge clk);
      check("t5_busy_pre", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t5_async_data", {24'd0, data_out}, 32'd0);
      check("t5_async_led", {24'd0, led_out}, 32'd0);
      check("t5_async_busy", {31'd0, busy}, 32'd0);
      check("t5_async_dv", {31'd0, data_valid}, 32'd0);
      sfp_rx = 1'b1;
      model_last = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(2 * CPB);
      check_settled("t5_after_rst");
      send_frame(8'h81, 1'b1, 0);
      idle(2 * CPB);
      check_settled("t5");

      // 6: LSB-first ordering
      send_frame(8'h01, 1'b1, 0);
      idle(2 * CPB);
      check("t6_led0", {31'd0, led_out[0]}, 32'd1);
      check("t6_led7_clear", {31'd0, led_out[7]}, 32'd0);
      send_frame(8'h80, 1'b1, 0);
      idle(2 * CPB);
      check("t6_led7", {31'd0, led_out[7]}, 32'd1);
      check("t6_led0_clear", {31'd0, led_out[0]}, 32'd0);
      check_settled("t6");

      // Randomized frames, mostly good, some with broken stop bits
      for (int n = 0; n < 24; n++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if ($urandom_range(0, 4) != 0) begin
            send_frame(b, 1'b1, 0);
            idle($urandom_range(0, 20));
         end else begin
            send_frame(b, 1'b0, CPB + $urandom_range(0, 30));
            idle(CPB + $urandom_range(0, 10));
         end
      end
      idle(3 * CPB);
      check_settled("rand");
      check("exp_q_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
